// File: rtl/flash_seq_ctrl.sv
// flash_seq_ctrl
//   Hardware JEDEC command sequencer for an 8 MiB parallel NOR FLASH.
//   On a start pulse it takes the FLASH bus, issues the unlock/command
//   write cycles for program, sector erase, chip erase or reset (F0),
//   then polls DQ6 toggle / DQ5 until the device reports completion.
//
// Ports
//   e          in   system clock, all logic on its rising edge
//   _reset     in   asynchronous active-low reset
//   start      in   one-cycle request, only honoured while idle
//   op         in   00 program, 01 sector erase, 10 chip erase, 11 reset
//   tgt_addr   in   program / sector address, latched at start
//   tgt_data   in   program data, latched at start
//   abort      in   level, sends any active operation down the abort path
//   f_din      in   FLASH data bus read value
//   f_addr     out  FLASH address (valid while f_own)
//   f_dout     out  FLASH write data (valid while f_own)
//   f_we_n     out  FLASH write strobe, active low
//   f_oe_n     out  FLASH output enable, active low
//   f_own      out  sequencer owns the FLASH bus
//   busy       out  operation in progress
//   done       out  one-cycle completion pulse
//   err        out  sticky error flag, cleared by the next accepted start
module flash_seq_ctrl #(
  parameter logic [22:0] UNLK_A1 = 23'h000555,
  parameter logic [22:0] UNLK_A2 = 23'h0002AA,
  parameter int          TO_W    = 20
) (
  input  logic        e,
  input  logic        _reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [22:0] tgt_addr,
  input  logic [7:0]  tgt_data,
  input  logic        abort,
  input  logic [7:0]  f_din,
  output logic [22:0] f_addr,
  output logic [7:0]  f_dout,
  output logic        f_we_n,
  output logic        f_oe_n,
  output logic        f_own,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE, S_WSET, S_WSTB, S_RD1, S_RD2, S_GAP, S_ASET, S_ASTB, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [1:0]        op_q, op_d;
  logic [22:0]       tgt_q, tgt_d;
  logic [7:0]        dat_q, dat_d;
  logic [TO_W-1:0]   to_q, to_d, to_inc;
  logic              chk_q, chk_d;
  logic              err_q, err_d;
  logic              d1_q, d1_d;      // DQ6 from the first read of a poll pair
  logic [2:0]        len_m1;
  logic              toggle;

  logic [22:0]       f_addr_q, f_addr_d;
  logic [7:0]        f_dout_q, f_dout_d;
  logic              f_we_n_q, f_we_n_d;
  logic              f_oe_n_q, f_oe_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [22:0]       wr_addr;
  logic [7:0]        wr_data;

  // Only DQ6 and DQ5 carry status during polling.
  logic unused_din;
  assign unused_din = ^{f_din[7], f_din[4:0]};

  always_comb begin
    case (op_q)
      2'b00:   len_m1 = 3'd3;
      2'b11:   len_m1 = 3'd0;
      default: len_m1 = 3'd5;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    op_d    = op_q;
    tgt_d   = tgt_q;
    dat_d   = dat_q;
    to_d    = to_q;
    chk_d   = chk_q;
    err_d   = err_q;
    d1_d    = d1_q;
    to_inc  = to_q + TO_W'(1);
    toggle  = d1_q ^ f_din[6];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          tgt_d   = tgt_addr;
          dat_d   = tgt_data;
          err_d   = 1'b0;
          chk_d   = 1'b0;
          step_d  = 3'd0;
          state_d = S_WSET;
        end
      end
      S_WSET: state_d = S_WSTB;
      S_WSTB: begin
        if (step_q < len_m1) begin
          step_d  = step_q + 3'd1;
          state_d = S_WSET;
        end else if (op_q == 2'b11) begin
          state_d = S_FIN;
        end else begin
          to_d    = '0;
          state_d = S_RD1;
        end
      end
      S_RD1: begin
        d1_d    = f_din[6];
        state_d = S_RD2;
      end
      S_RD2: begin
        // Compare against the live bus instead of waiting for a second register.
        if (!toggle) begin
          state_d = S_FIN;
        end else if (chk_q) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          // DQ5 high while still toggling: allow exactly one confirming pair.
          if (f_din[5]) chk_d = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP:  state_d = S_RD1;
      S_ASET: state_d = S_ASTB;
      S_ASTB: state_d = S_FIN;
      S_FIN: begin
        chk_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_RD1 || state_q == S_RD2 || state_q == S_GAP) begin
      to_d = to_inc;
      if (to_inc == '1) begin
        err_d   = 1'b1;
        state_d = S_ASET;
      end
    end

    if (abort && state_q != S_IDLE && state_q != S_FIN &&
        state_q != S_ASET && state_q != S_ASTB) begin
      err_d   = 1'b1;
      state_d = S_ASET;
    end
  end

  // Command table for the step about to be driven.
  always_comb begin
    wr_addr = UNLK_A1;
    wr_data = 8'hAA;
    if (op_d == 2'b11) begin
      wr_addr = tgt_d;
      wr_data = 8'hF0;
    end else begin
      case (step_d)
        3'd1: begin wr_addr = UNLK_A2; wr_data = 8'h55; end
        3'd2: wr_data = (op_d == 2'b00) ? 8'hA0 : 8'h80;
        3'd3: if (op_d == 2'b00) begin wr_addr = tgt_d; wr_data = dat_d; end
        3'd4: begin wr_addr = UNLK_A2; wr_data = 8'h55; end
        3'd5: begin
          if (op_d == 2'b01) begin wr_addr = tgt_d; wr_data = 8'h30; end
          else wr_data = 8'h10;
        end
        default: ;
      endcase
    end
  end

  // Pin values are decoded from the next state so they are registered
  // and valid for the whole cycle in which that state is active.
  always_comb begin
    f_addr_d = '0;
    f_dout_d = '0;
    f_we_n_d = 1'b1;
    f_oe_n_d = 1'b1;
    busy_d   = (state_d != S_IDLE);
    done_d   = 1'b0;
    case (state_d)
      S_WSET: begin f_addr_d = wr_addr; f_dout_d = wr_data; end
      S_WSTB: begin f_addr_d = wr_addr; f_dout_d = wr_data; f_we_n_d = 1'b0; end
      S_RD1, S_RD2: begin f_addr_d = tgt_d; f_oe_n_d = 1'b0; end
      S_GAP:  f_addr_d = tgt_d;
      S_ASET: begin f_addr_d = tgt_d; f_dout_d = 8'hF0; end
      S_ASTB: begin f_addr_d = tgt_d; f_dout_d = 8'hF0; f_we_n_d = 1'b0; end
      S_FIN:  begin f_addr_d = tgt_d; done_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge e or negedge _reset) begin
    if (!_reset) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      op_q     <= '0;
      tgt_q    <= '0;
      dat_q    <= '0;
      to_q     <= '0;
      chk_q    <= 1'b0;
      err_q    <= 1'b0;
      d1_q     <= 1'b0;
      f_addr_q <= '0;
      f_dout_q <= '0;
      f_we_n_q <= 1'b1;
      f_oe_n_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      op_q     <= op_d;
      tgt_q    <= tgt_d;
      dat_q    <= dat_d;
      to_q     <= to_d;
      chk_q    <= chk_d;
      err_q    <= err_d;
      d1_q     <= d1_d;
      f_addr_q <= f_addr_d;
      f_dout_q <= f_dout_d;
      f_we_n_q <= f_we_n_d;
      f_oe_n_q <= f_oe_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign f_addr = f_addr_q;
  assign f_dout = f_dout_q;
  assign f_we_n = f_we_n_q;
  assign f_oe_n = f_oe_n_q;
  assign f_own  = busy_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_flash_seq_ctrl.sv
// Testbench for flash_seq_ctrl: a behavioural FLASH status model drives
// f_din, a monitor records every write strobe/read/done, and each test
// task compares the recorded bus activity with the command list and
// timing derived from the operation rules.
module tb_flash_seq_ctrl;

  localparam logic [22:0] A1 = 23'h000555;
  localparam logic [22:0] A2 = 23'h0002AA;
  localparam int BIG = 1000000;

  logic        e;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [22:0] tgt_addr;
  logic [7:0]  tgt_data;
  logic        abort;
  logic [7:0]  f_din;
  logic [22:0] f_addr;
  logic [7:0]  f_dout;
  logic        f_we_n, f_oe_n, f_own, busy, done, err;

  int pass_cnt = 0;
  int total_cnt = 0;

  flash_seq_ctrl #(.TO_W(4)) dut (
    .e(e), ._reset(reset_n), .start(start), .op(op), .tgt_addr(tgt_addr),
    .tgt_data(tgt_data), .abort(abort), .f_din(f_din), .f_addr(f_addr),
    .f_dout(f_dout), .f_we_n(f_we_n), .f_oe_n(f_oe_n), .f_own(f_own),
    .busy(busy), .done(done), .err(err)
  );

  initial e = 1'b0;
  always #5 e = ~e;

  // FLASH status model: DQ6 flips after each completed read until the
  // toggle budget is used up; DQ5 is a constant set by the test.
  int   budget = 0;
  logic dq5 = 1'b0;
  int   rd_cnt = 0;
  logic t6;
  always @(posedge e) begin
    if (start && !busy) rd_cnt <= 0;
    else if (!f_oe_n) rd_cnt <= rd_cnt + 1;
  end
  assign t6    = (rd_cnt < budget) ? rd_cnt[0] : budget[0];
  assign f_din = {1'b0, t6, dq5, 5'b0};

  // Bus monitor, sampled mid-cycle.
  logic [30:0] stb_q[$];
  int          stb_cyc[$];
  logic [30:0] exp_q[$];
  int cyc = 0;
  int reads_seen = 0, done_cnt = 0, done_cyc = -1, own_drop = -1;
  int start_cyc = 0, overlap = 0;
  always @(negedge e) begin
    if (start && !busy && reset_n) begin
      stb_q.delete();
      stb_cyc.delete();
      reads_seen <= 0;
      done_cnt   <= 0;
      done_cyc   <= -1;
      own_drop   <= -1;
      start_cyc  <= cyc;
    end else begin
      if (!f_we_n) begin
        stb_q.push_back({f_addr, f_dout});
        stb_cyc.push_back(cyc);
      end
      if (!f_oe_n) reads_seen <= reads_seen + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (!f_own && done_cyc >= 0 && own_drop < 0) own_drop <= cyc;
      if (!f_we_n && !f_oe_n) overlap <= overlap + 1;
    end
    cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge e);
    #1;
  endtask

  function automatic void build_exp(input logic [1:0] o, input logic [22:0] a,
                                    input logic [7:0] d);
    exp_q.delete();
    if (o == 2'b11) begin
      exp_q.push_back({a, 8'hF0});
    end else begin
      exp_q.push_back({A1, 8'hAA});
      exp_q.push_back({A2, 8'h55});
      if (o == 2'b00) begin
        exp_q.push_back({A1, 8'hA0});
        exp_q.push_back({a, d});
      end else begin
        exp_q.push_back({A1, 8'h80});
        exp_q.push_back({A1, 8'hAA});
        exp_q.push_back({A2, 8'h55});
        exp_q.push_back((o == 2'b01) ? {a, 8'h30} : {A1, 8'h10});
      end
    end
  endfunction

  function automatic bit strobes_match();
    if (stb_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (stb_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int last_stb(input int back);
    if (stb_cyc.size() > back) return stb_cyc[stb_cyc.size() - 1 - back];
    return -1000;
  endfunction

  task automatic launch(input logic [1:0] o, input logic [22:0] a,
                        input logic [7:0] d, input int n, input logic q5);
    budget = n;
    dq5 = q5;
    op = o;
    tgt_addr = a;
    tgt_data = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int k = 0;
    while (done_cnt == 0 && k < 300) begin
      tick();
      k++;
    end
    ok = (done_cnt != 0);
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; op = '0; tgt_addr = '0; tgt_data = '0;
    #12;
    total_cnt++; if (f_addr !== 23'h0) $display("FAIL reset_addr got=%h exp=0", f_addr); else pass_cnt++;
    total_cnt++; if (f_dout !== 8'h0) $display("FAIL reset_dout got=%h exp=0", f_dout); else pass_cnt++;
    total_cnt++; if (f_we_n !== 1'b1) $display("FAIL reset_we_n got=%b exp=1", f_we_n); else pass_cnt++;
    total_cnt++; if (f_oe_n !== 1'b1) $display("FAIL reset_oe_n got=%b exp=1", f_oe_n); else pass_cnt++;
    total_cnt++; if (f_own !== 1'b0) $display("FAIL reset_own got=%b exp=0", f_own); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else pass_cnt++;
    @(posedge e); #1;
    reset_n = 1'b1;
    tick();
    $display("reset: outputs checked");
  endtask

  task automatic test_op(input logic [1:0] o, input logic [22:0] a,
                         input logic [7:0] d, input int n);
    bit ok;
    int pairs = (n + 1) / 2 + 1;
    int len = (o == 2'b00) ? 4 : 6;
    build_exp(o, a, d);
    launch(o, a, d, n, 1'b0);
    wait_done(ok);
    total_cnt++; if (!ok) $display("FAIL op_done_timeout got=no_done exp=done"); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL op_done_count got=%0d exp=1", done_cnt); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL op_err got=%b exp=0", err); else pass_cnt++;
    total_cnt++; if (strobes_match() !== 1'b1) $display("FAIL op_strobes got=%0d strobes exp=%0d", stb_q.size(), exp_q.size()); else pass_cnt++;
    total_cnt++; if (reads_seen !== 2 * pairs) $display("FAIL op_reads got=%0d exp=%0d", reads_seen, 2 * pairs); else pass_cnt++;
    total_cnt++; if (last_stb(len - 1) - start_cyc !== 2) $display("FAIL op_first_strobe got=%0d exp=2", last_stb(len - 1) - start_cyc); else pass_cnt++;
    total_cnt++; if (last_stb(0) - last_stb(len - 1) !== 2 * (len - 1)) $display("FAIL op_write_phase got=%0d exp=%0d", last_stb(0) - last_stb(len - 1), 2 * (len - 1)); else pass_cnt++;
    total_cnt++; if (done_cyc - last_stb(0) !== 3 * pairs) $display("FAIL op_done_latency got=%0d exp=%0d", done_cyc - last_stb(0), 3 * pairs); else pass_cnt++;
    total_cnt++; if (own_drop - done_cyc !== 1) $display("FAIL op_own_drop got=%0d exp=1", own_drop - done_cyc); else pass_cnt++;
    $display("op=%0d tgt=%06h data=%02h toggles=%0d strobes=%0d reads=%0d err=%0b",
             o, a, d, n, stb_q.size(), reads_seen, err);
  endtask

  task automatic test_reset_op(input logic [22:0] a);
    bit ok;
    build_exp(2'b11, a, 8'h00);
    launch(2'b11, a, 8'h00, 0, 1'b0);
    wait_done(ok);
    total_cnt++; if (!ok) $display("FAIL rstop_done_timeout got=no_done exp=done"); else pass_cnt++;
    total_cnt++; if (strobes_match() !== 1'b1) $display("FAIL rstop_strobes got=%0d exp=1", stb_q.size()); else pass_cnt++;
    total_cnt++; if (reads_seen !== 0) $display("FAIL rstop_reads got=%0d exp=0", reads_seen); else pass_cnt++;
    total_cnt++; if (done_cyc - start_cyc !== 3) $display("FAIL rstop_latency got=%0d exp=3", done_cyc - start_cyc); else pass_cnt++;
    $display("op=3 tgt=%06h strobes=%0d done_after=%0d err=%0b", a, stb_q.size(), done_cyc - start_cyc, err);
  endtask

  task automatic test_dq5();
    bit ok;
    logic [22:0] a = 23'($urandom);
    logic [7:0]  d = 8'($urandom);
    build_exp(2'b00, a, d);
    launch(2'b00, a, d, BIG, 1'b1);
    wait_done(ok);
    total_cnt++; if (!ok) $display("FAIL dq5_done_timeout got=no_done exp=done"); else pass_cnt++;
    total_cnt++; if (err !== 1'b1) $display("FAIL dq5_err got=%b exp=1", err); else pass_cnt++;
    total_cnt++; if (reads_seen !== 4) $display("FAIL dq5_reads got=%0d exp=4", reads_seen); else pass_cnt++;
    total_cnt++; if (strobes_match() !== 1'b1) $display("FAIL dq5_strobes got=%0d exp=%0d", stb_q.size(), exp_q.size()); else pass_cnt++;
    $display("dq5 fail: tgt=%06h reads=%0d strobes=%0d err=%0b", a, reads_seen, stb_q.size(), err);
  endtask

  task automatic test_timeout();
    bit ok;
    logic [22:0] a = 23'($urandom);
    build_exp(2'b01, a, 8'h00);
    exp_q.push_back({a, 8'hF0});
    launch(2'b01, a, 8'h00, BIG, 1'b0);
    wait_done(ok);
    total_cnt++; if (!ok) $display("FAIL tmo_done_timeout got=no_done exp=done"); else pass_cnt++;
    total_cnt++; if (err !== 1'b1) $display("FAIL tmo_err got=%b exp=1", err); else pass_cnt++;
    total_cnt++; if (reads_seen !== 10) $display("FAIL tmo_reads got=%0d exp=10", reads_seen); else pass_cnt++;
    total_cnt++; if (strobes_match() !== 1'b1) $display("FAIL tmo_strobes got=%0d exp=%0d", stb_q.size(), exp_q.size()); else pass_cnt++;
    total_cnt++; if (last_stb(0) - last_stb(1) !== 17) $display("FAIL tmo_f0_gap got=%0d exp=17", last_stb(0) - last_stb(1)); else pass_cnt++;
    $display("timeout: tgt=%06h reads=%0d strobes=%0d err=%0b", a, reads_seen, stb_q.size(), err);
  endtask

  task automatic test_abort();
    bit ok;
    logic [22:0] a = 23'($urandom);
    logic [7:0]  d = 8'($urandom);
    logic [22:0] a2 = 23'($urandom);
    exp_q.delete();
    exp_q.push_back({A1, 8'hAA});
    exp_q.push_back({A2, 8'h55});
    exp_q.push_back({a, 8'hF0});
    launch(2'b00, a, d, 0, 1'b0);
    tick(); tick(); tick();
    total_cnt++; if (f_we_n !== 1'b0) $display("FAIL abort_in_strobe got=%b exp=0", f_we_n); else pass_cnt++;
    abort = 1'b1;
    tick();
    total_cnt++; if (f_we_n !== 1'b1) $display("FAIL abort_we_release got=%b exp=1", f_we_n); else pass_cnt++;
    abort = 1'b0;
    wait_done(ok);
    total_cnt++; if (!ok) $display("FAIL abort_done_timeout got=no_done exp=done"); else pass_cnt++;
    total_cnt++; if (err !== 1'b1) $display("FAIL abort_err got=%b exp=1", err); else pass_cnt++;
    total_cnt++; if (strobes_match() !== 1'b1) $display("FAIL abort_strobes got=%0d exp=3", stb_q.size()); else pass_cnt++;
    $display("abort: tgt=%06h strobes=%0d err=%0b", a, stb_q.size(), err);
    launch(2'b11, a2, 8'h00, 0, 1'b0);
    total_cnt++; if (err !== 1'b0) $display("FAIL abort_err_clear got=%b exp=0", err); else pass_cnt++;
    wait_done(ok);
    total_cnt++; if (!ok) $display("FAIL abort_restart_timeout got=no_done exp=done"); else pass_cnt++;
    $display("restart after abort: tgt=%06h err=%0b", a2, err);
  endtask

  task automatic test_start_while_busy();
    bit ok;
    logic [22:0] a = 23'($urandom);
    logic [7:0]  d = 8'($urandom);
    build_exp(2'b00, a, d);
    launch(2'b00, a, d, 2, 1'b0);
    tick(); tick(); tick();
    op = 2'b01;
    tgt_addr = ~a;
    tgt_data = ~d;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(ok);
    total_cnt++; if (!ok) $display("FAIL busy_start_timeout got=no_done exp=done"); else pass_cnt++;
    total_cnt++; if (strobes_match() !== 1'b1) $display("FAIL busy_start_strobes got=%0d exp=%0d", stb_q.size(), exp_q.size()); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL busy_start_done_count got=%0d exp=1", done_cnt); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL busy_start_idle got=%b exp=0", busy); else pass_cnt++;
    $display("start while busy: tgt=%06h strobes=%0d done=%0d", a, stb_q.size(), done_cnt);
  endtask

  task automatic test_async_reset();
    int k = 0;
    logic [22:0] a = 23'($urandom);
    launch(2'b00, a, 8'h3C, BIG, 1'b0);
    while (f_oe_n !== 1'b0 && k < 40) begin
      tick();
      k++;
    end
    total_cnt++; if (f_oe_n !== 1'b0) $display("FAIL areset_reach_rd1 got=%b exp=0", f_oe_n); else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (f_own !== 1'b0) $display("FAIL areset_own got=%b exp=0", f_own); else pass_cnt++;
    total_cnt++; if (f_oe_n !== 1'b1) $display("FAIL areset_oe_n got=%b exp=1", f_oe_n); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL areset_busy got=%b exp=0", busy); else pass_cnt++;
    tick(); tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    total_cnt++; if (stb_q.size() !== 4) $display("FAIL areset_no_f0 got=%0d exp=4", stb_q.size()); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL areset_stay_idle got=%b exp=0", busy); else pass_cnt++;
    $display("async reset in RD1: tgt=%06h strobes=%0d busy=%0b", a, stb_q.size(), busy);
  endtask

  initial begin
    test_reset();
    test_op(2'b00, 23'h012345, 8'h5A, 3);
    test_op(2'b01, 23'h040000, 8'h00, 0);
    test_op(2'b10, 23'($urandom), 8'($urandom), 2);
    for (int i = 0; i < 5; i++) begin
      test_op(2'($urandom_range(0, 2)), 23'($urandom), 8'($urandom),
              int'($urandom_range(0, 5)));
    end
    test_reset_op(23'($urandom));
    test_dq5();
    test_timeout();
    test_abort();
    test_start_while_busy();
    test_async_reset();
    total_cnt++; if (overlap !== 0) $display("FAIL we_oe_overlap got=%0d exp=0", overlap); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
